// File: rtl/uart_fifo_ctrl_if.sv
// Push/pop request and pointer/flag bundle between a FIFO user and its controller.
// master: drives wr/rd/clr_err; slave: returns wr_en, addresses, count and flags.
interface uart_fifo_ctrl_if #(
    parameter int addr_width = 3
);
    logic                  wr;
    logic                  rd;
    logic                  clr_err;
    logic                  wr_en;
    logic [addr_width-1:0] wr_addr;
    logic [addr_width-1:0] rd_addr;
    logic                  full;
    logic                  empty;
    logic [addr_width:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, rd, clr_err,
        input  wr_en, wr_addr, rd_addr, full, empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  wr, rd, clr_err,
        output wr_en, wr_addr, rd_addr, full, empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// Pointer/flag controller for a UART FIFO next to a sync-write, async-read RAM.
// Ports: clk, reset_n (sync, active-low), bus (uart_fifo_ctrl_if.slave).
module uart_fifo_ctrl #(
    parameter int addr_width = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    uart_fifo_ctrl_if.slave bus
);
    localparam logic [addr_width:0] depth = {1'b1, {addr_width{1'b0}}};

    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [addr_width:0]   cnt;
    logic                  full_q;
    logic                  empty_q;
    logic                  ovf_q;
    logic                  unf_q;

    logic                  do_wr;
    logic                  do_rd;
    logic [addr_width:0]   cnt_nxt;

    // A push into a full FIFO is still accepted when a pop frees the
    // oldest slot in the same cycle (full implies not empty).
    assign do_wr = bus.wr & (~full_q | bus.rd);
    assign do_rd = bus.rd & ~empty_q;

    always_comb begin
        cnt_nxt = cnt;
        unique case ({do_wr, do_rd})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt     <= cnt_nxt;
            full_q  <= (cnt_nxt == depth);
            empty_q <= (cnt_nxt == '0);
            // Set has priority over clear on the sticky flags.
            if (bus.wr & ~do_wr) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end
            if (bus.rd & empty_q) begin
                unf_q <= 1'b1;
            end else if (bus.clr_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign bus.wr_en     = do_wr;
    assign bus.wr_addr   = wr_ptr;
    assign bus.rd_addr   = rd_ptr;
    assign bus.count     = cnt;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Testbench for uart_fifo_ctrl with a behavioural RAM and a data scoreboard.
// Ports: none (top-level bench).
module tb_uart_fifo_ctrl;
    localparam int aw = 3;
    localparam int depth = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic [7:0] wdata;
    logic [7:0] ram [depth];

    int total = 0;
    int bad = 0;

    int mcount;
    int mwp;
    int mrp;
    int movf;
    int munf;
    logic [7:0] sb [$];

    uart_fifo_ctrl_if #(.addr_width(aw)) bus ();

    uart_fifo_ctrl #(.addr_width(aw)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Storage RAM: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (bus.wr_en === 1'b1) begin
            ram[bus.wr_addr] <= wdata;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        chk("count", int'(bus.count), mcount);
        chk("full", int'(bus.full), int'(mcount == depth));
        chk("empty", int'(bus.empty), int'(mcount == 0));
        chk("wr_addr", int'(bus.wr_addr), mwp);
        chk("rd_addr", int'(bus.rd_addr), mrp);
        chk("overflow", int'(bus.overflow), movf);
        chk("underflow", int'(bus.underflow), munf);
    endtask

    task automatic step(input logic w, input logic r,
                        input logic c, input logic [7:0] d);
        logic aw_ok;
        logic ar_ok;
        logic [7:0] exp;
        @(negedge clk);
        chk_state();
        bus.wr = w;
        bus.rd = r;
        bus.clr_err = c;
        wdata = d;
        #1;
        aw_ok = w && (mcount < depth || r);
        ar_ok = r && (mcount > 0);
        chk("wr_en", int'(bus.wr_en), int'(aw_ok));
        if (ar_ok) begin
            exp = sb.pop_front();
            chk("rdata", int'(ram[bus.rd_addr]), int'(exp));
        end
        if (aw_ok) begin
            sb.push_back(d);
        end
        if (w && !aw_ok) movf = 1;
        else if (c) movf = 0;
        if (r && mcount == 0) munf = 1;
        else if (c) munf = 0;
        mcount = mcount + int'(aw_ok) - int'(ar_ok);
        mwp = (mwp + int'(aw_ok)) % depth;
        mrp = (mrp + int'(ar_ok)) % depth;
    endtask

    initial begin
        bus.wr = 1'b1;
        bus.rd = 1'b1;
        bus.clr_err = 1'b0;
        wdata = 8'h00;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", int'(bus.wr_en), 1);
        mcount = 0;
        mwp = 0;
        mrp = 0;
        movf = 0;
        munf = 0;
        chk_state();
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        reset_n = 1'b1;
        step(0, 0, 0, 8'h00);

        // Fill, then overflow
        for (int i = 0; i < depth; i++) step(1, 0, 0, 8'(8'h10 + i));
        step(1, 0, 0, 8'h99);

        // Drain, then underflow, then clear
        for (int i = 0; i < depth; i++) step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h00);

        // Set wins over clear
        step(0, 1, 1, 8'h00);
        step(0, 0, 1, 8'h00);

        // Simultaneous push/pop while full
        for (int i = 0; i < depth; i++) step(1, 0, 0, 8'(8'h20 + i));
        step(1, 1, 0, 8'hAA);
        for (int i = 0; i < depth; i++) step(0, 1, 0, 8'h00);

        // Simultaneous push/pop while empty
        step(0, 0, 1, 8'h00);
        step(1, 1, 0, 8'h55);
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h00);

        // Random bursts across pointer wrap
        for (int i = 0; i < 30; i++) begin
            int len;
            int mode;
            len = $urandom_range(1, 4);
            mode = $urandom_range(0, 3);
            for (int j = 0; j < len; j++) begin
                step(mode[1], mode[0], 0, 8'($urandom_range(0, 255)));
            end
        end

        // Drain remainder and confirm scoreboard emptied with it
        while (mcount > 0) step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("sb_size", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
